ahb_lite_interconnect: RTL and testbench

//  Single-manager AHB-Lite interconnect between renode_ahb_manager and N AHB subordinates (e.g. mem_ahb).

---
 rtl/ahb_ic_pkg.sv | 29 ++
 rtl/ahb_default_subordinate.sv | 55 +++++
 rtl/ahb_lite_interconnect.sv | 143 ++++++++++++++
 tb/tb_ahb_lite_interconnect.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_ic_pkg.sv
// ---------------------------------------------------------------------------
// ahb_ic_pkg
// Shared types and constants for the single-manager AHB-Lite interconnect:
// HTRANS encoding, HRESP values and the default-subordinate state encoding.
// ---------------------------------------------------------------------------
package ahb_ic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } ds_state_e;

   // A transfer carries data only for NONSEQ and SEQ; IDLE/BUSY never do.
   function automatic logic is_active(input logic [1:0] htrans);
      return (htrans == NONSEQ) || (htrans == SEQ);
   endfunction

endpackage

// File: rtl/ahb_default_subordinate.sv
// ---------------------------------------------------------------------------
// ahb_default_subordinate
// Answers transfers to unmapped space. Active (NONSEQ/SEQ) transfers get the
// two-cycle AHB ERROR response; IDLE/BUSY get OKAY with no wait states.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   hready         bus HREADY (address phase accepted when high)
//   unmapped       current address phase decodes to no subordinate
//   trans_active   current HTRANS is NONSEQ or SEQ
//   hreadyout      default-subordinate HREADYOUT
//   hresp          default-subordinate HRESP (1 = ERROR)
// ---------------------------------------------------------------------------
module ahb_default_subordinate
   import ahb_ic_pkg::*;
(
   input  logic HCLK,
   input  logic HRESETn,
   input  logic hready,
   input  logic unmapped,
   input  logic trans_active,
   output logic hreadyout,
   output logic hresp
);

   ds_state_e state_q;
   ds_state_e state_d;
   logic      start_err;

   assign start_err = hready && unmapped && trans_active;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= DS_IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every variable gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DS_IDLE: if (start_err) state_d = DS_ERR1;
         DS_ERR1: state_d = DS_ERR2;
         DS_ERR2: state_d = start_err ? DS_ERR1 : DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
   end

   // Outputs depend on the state register only, so the bus HREADY that feeds
   // start_err never loops back through this block.
   assign hreadyout = (state_q != DS_ERR1);
   assign hresp     = (state_q == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// ahb_lite_interconnect
// Single-manager AHB-Lite interconnect towards SubordinatesCount subordinates.
// The address phase is decoded combinationally to s_hsel (lowest index wins on
// overlap); the selection is registered for the data phase and used to return
// HRDATA/HREADYOUT/HRESP to the manager. Unmapped addresses go to a built-in
// default subordinate.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   m_haddr        manager address-phase address
//   m_htrans       manager transfer type
//   m_hrdata       read data to the manager
//   m_hready       bus HREADY, also the HREADYin of every subordinate
//   m_hresp        response to the manager, 1 = ERROR
//   s_hsel         per-subordinate select (one-hot or zero)
//   s_hrdata       packed per-subordinate read data, index 0 in the LSBs
//   s_hreadyout    per-subordinate HREADYOUT
//   s_hresp        per-subordinate HRESP
// Optional (macro AHB_IC_ERR_LOG_EN):
//   err_clr        clears err_valid
//   err_valid      sticky flag, set by the first transfer ending in ERROR
//   err_addr       address-phase HADDR of that transfer
// ---------------------------------------------------------------------------
module ahb_lite_interconnect
   import ahb_ic_pkg::*;
#(
   parameter int SubordinatesCount = 2,
   parameter int AddressWidth      = 32,
   parameter int DataWidth         = 32,
   parameter logic [AddressWidth-1:0] BaseAddr [SubordinatesCount] =
      '{32'h0000_0000, 32'h1000_0000},
   parameter logic [AddressWidth-1:0] AddrMask [SubordinatesCount] =
      '{32'hF000_0000, 32'hF000_0000}
) (
   input  logic                                   HCLK,
   input  logic                                   HRESETn,
   input  logic [AddressWidth-1:0]                m_haddr,
   input  logic [1:0]                             m_htrans,
   output logic [DataWidth-1:0]                   m_hrdata,
   output logic                                   m_hready,
   output logic                                   m_hresp,
   output logic [SubordinatesCount-1:0]           s_hsel,
   input  logic [SubordinatesCount*DataWidth-1:0] s_hrdata,
   input  logic [SubordinatesCount-1:0]           s_hreadyout,
   input  logic [SubordinatesCount-1:0]           s_hresp
`ifdef AHB_IC_ERR_LOG_EN
   ,
   input  logic                                   err_clr,
   output logic                                   err_valid,
   output logic [AddressWidth-1:0]                err_addr
`endif
);

   // Target index SubordinatesCount is the default subordinate.
   localparam int DsIdx   = SubordinatesCount;
   localparam int Targets = SubordinatesCount + 1;

   logic [SubordinatesCount-1:0] hit;
   logic                         unmapped;
   logic [Targets-1:0]           dsel_q;
   logic                         ds_hreadyout;
   logic                         ds_hresp;

   // Address decode: the first matching region claims the transfer.
   always_comb begin
      hit      = '0;
      unmapped = 1'b1;
      for (int i = 0; i < SubordinatesCount; i++) begin
         if (unmapped && ((m_haddr & AddrMask[i]) == BaseAddr[i])) begin
            hit[i]   = 1'b1;
            unmapped = 1'b0;
         end
      end
   end

   // Select is not qualified by HTRANS; subordinates do that themselves.
   assign s_hsel = hit;

   // Data-phase select advances only when the current data phase completes,
   // so wait states keep the response path pointed at the same target.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)      dsel_q <= {1'b1, {SubordinatesCount{1'b0}}};
      else if (m_hready) dsel_q <= {unmapped, hit};
   end

   ahb_default_subordinate u_ds (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .hready       (m_hready),
      .unmapped     (unmapped),
      .trans_active (is_active(m_htrans)),
      .hreadyout    (ds_hreadyout),
      .hresp        (ds_hresp)
   );

   // dsel_q is one-hot, so an OR of the gated sources is a plain mux. The
   // default subordinate contributes no read data, which yields zero.
   always_comb begin
      m_hrdata = '0;
      m_hready = 1'b0;
      m_hresp  = HRESP_OKAY;
      for (int i = 0; i < SubordinatesCount; i++) begin
         if (dsel_q[i]) begin
            m_hrdata = m_hrdata | s_hrdata[i*DataWidth +: DataWidth];
            m_hready = m_hready | s_hreadyout[i];
            m_hresp  = m_hresp  | s_hresp[i];
         end
      end
      if (dsel_q[DsIdx]) begin
         m_hready = m_hready | ds_hreadyout;
         m_hresp  = m_hresp  | ds_hresp;
      end
   end

`ifdef AHB_IC_ERR_LOG_EN
   logic [AddressWidth-1:0] dp_addr_q;
   logic                    err_end;

   // Address of the transfer currently in its data phase.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)      dp_addr_q <= '0;
      else if (m_hready) dp_addr_q <= m_haddr;
   end

   // Second ERROR cycle: HRESP high while the data phase completes.
   assign err_end = m_hready && (m_hresp == HRESP_ERROR);

   // A new capture is allowed when the log is empty or being cleared in the
   // same cycle; the capture then takes precedence over the clear.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_valid <= 1'b0;
         err_addr  <= '0;
      end else if (err_end && (!err_valid || err_clr)) begin
         err_valid <= 1'b1;
         err_addr  <= dp_addr_q;
      end else if (err_clr) begin
         err_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_interconnect
// Directed bench for ahb_lite_interconnect with N=2: subordinate 0 is a small
// zero-wait memory, subordinate 1 returns (HADDR ^ 32'h5A5A_0000) after a
// programmable number of wait states. The driver pushes the expected data
// phase into a queue when a transfer is accepted; an independent monitor
// pops and compares at every data-phase cycle.
// ---------------------------------------------------------------------------
module tb_ahb_lite_interconnect;
   import ahb_ic_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] m_haddr;
   logic [1:0]  m_htrans;
   logic        m_hwrite;
   logic [31:0] m_hwdata;
   logic [31:0] m_hrdata;
   logic        m_hready;
   logic        m_hresp;
   logic [1:0]  s_hsel;
   logic [63:0] s_hrdata;
   logic [1:0]  s_hreadyout;
   logic [1:0]  s_hresp;
`ifdef AHB_IC_ERR_LOG_EN
   logic        err_clr;
   logic        err_valid;
   logic [31:0] err_addr;
`endif

   int checks = 0;
   int errors = 0;

   ahb_lite_interconnect #(
      .SubordinatesCount (2),
      .AddressWidth      (32),
      .DataWidth         (32),
      .BaseAddr          ('{32'h0000_0000, 32'h1000_0000}),
      .AddrMask          ('{32'hF000_0000, 32'hF000_0000})
   ) dut (
      .HCLK        (clk),
      .HRESETn     (rst_n),
      .m_haddr     (m_haddr),
      .m_htrans    (m_htrans),
      .m_hrdata    (m_hrdata),
      .m_hready    (m_hready),
      .m_hresp     (m_hresp),
      .s_hsel      (s_hsel),
      .s_hrdata    (s_hrdata),
      .s_hreadyout (s_hreadyout),
      .s_hresp     (s_hresp)
`ifdef AHB_IC_ERR_LOG_EN
      ,
      .err_clr     (err_clr),
      .err_valid   (err_valid),
      .err_addr    (err_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- subordinate 0: 16-word memory, zero wait ----------------
   logic [31:0] mem [16];
   logic        s0_dp;
   logic        s0_wr;
   logic [3:0]  s0_idx;

   initial for (int i = 0; i < 16; i++) mem[i] = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_dp  <= 1'b0;
         s0_wr  <= 1'b0;
         s0_idx <= '0;
      end else if (m_hready) begin
         if (s0_dp && s0_wr) mem[s0_idx] <= m_hwdata;
         s0_dp  <= s_hsel[0] && m_htrans[1];
         s0_wr  <= m_hwrite;
         s0_idx <= m_haddr[5:2];
      end
   end

   // ---------------- subordinate 1: patterned data, programmable waits -------
   int          s1_wait;
   logic [3:0]  s1_cnt;
   logic [31:0] s1_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_cnt   <= '0;
         s1_rdata <= '0;
      end else if (s1_cnt != 0) begin
         s1_cnt <= s1_cnt - 4'd1;
      end else if (m_hready && s_hsel[1] && m_htrans[1]) begin
         s1_cnt   <= 4'(s1_wait);
         s1_rdata <= m_haddr ^ 32'h5A5A_0000;
      end
   end

   assign s_hrdata    = {s1_rdata, (s0_dp ? mem[s0_idx] : 32'h0)};
   assign s_hreadyout = {(s1_cnt == 0), 1'b1};
   assign s_hresp     = 2'b00;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        chk_data;
      logic [31:0] data;
      logic        resp;
      int          waits;
   } exp_t;

   exp_t sb[$];

   // Monitor: walks every data-phase cycle of active transfers.
   logic dp_active = 1'b0;
   int   waits_seen = 0;
   exp_t cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         dp_active  = 1'b0;
         waits_seen = 0;
      end else begin
         if (dp_active) begin
            if (sb.size() == 0) begin
               if (m_hready) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_data_phase: got resp %0b expected no transfer", m_hresp);
               end
            end else if (!m_hready) begin
               check({sb[0].name, "_wait_resp"}, 32'(m_hresp), 32'(sb[0].resp));
               waits_seen++;
            end else begin
               cur = sb.pop_front();
               check({cur.name, "_resp"}, 32'(m_hresp), 32'(cur.resp));
               check({cur.name, "_waits"}, 32'(waits_seen), 32'(cur.waits));
               if (cur.chk_data) check({cur.name, "_rdata"}, m_hrdata, cur.data);
               waits_seen = 0;
            end
         end
         if (m_hready) dp_active = m_htrans[1];
      end
   end

   // ---------------- driver ----------------
   task automatic wait_accept(input string name);
      int n = 0;
      forever begin
         @(negedge clk);
         if (m_hready) break;
         n++;
         if (n > 20) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got hready 0 for %0d cycles expected 1", name, n);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input string name, input logic [31:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [31:0] wdata, input logic [1:0] exp_hsel,
                        input logic chk_data, input logic [31:0] exp_data,
                        input logic exp_resp, input int exp_waits);
      exp_t e;
      m_haddr  = addr;
      m_htrans = trans;
      m_hwrite = wr;
      #1 check({name, "_hsel"}, 32'(s_hsel), 32'(exp_hsel));
      wait_accept(name);
      if (trans[1]) begin
         e.name     = name;
         e.chk_data = chk_data;
         e.data     = exp_data;
         e.resp     = exp_resp;
         e.waits    = exp_waits;
         sb.push_back(e);
      end
      m_hwdata = wr ? wdata : 32'h0;
      m_htrans = IDLE;
      m_hwrite = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b1;
      m_haddr  = '0;
      m_htrans = IDLE;
      m_hwrite = 1'b0;
      m_hwdata = '0;
      s1_wait  = 0;
`ifdef AHB_IC_ERR_LOG_EN
      err_clr  = 1'b0;
`endif
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_hready", 32'(m_hready), 32'h1);
      check("rst_hresp",  32'(m_hresp),  32'h0);
      check("rst_hrdata", m_hrdata,      32'h0);
`ifdef AHB_IC_ERR_LOG_EN
      check("rst_err_valid", 32'(err_valid), 32'h0);
      check("rst_err_addr",  err_addr,       32'h0);
`endif
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: write then read back through subordinate 0
      issue("t1_wr", 32'h0000_0010, NONSEQ, 1'b1, 32'hDEAD_BEEF, 2'b01, 1'b0, 32'h0, HRESP_OKAY, 0);
      issue("t1_rd", 32'h0000_0010, NONSEQ, 1'b0, 32'h0, 2'b01, 1'b1, 32'hDEAD_BEEF, HRESP_OKAY, 0);

      // 2: subordinate 1 with 3 waits; the next (unmapped) address phase is
      //    presented during the waits and must not disturb the response path.
      s1_wait = 3;
      issue("t2_rd", 32'h1000_0004, NONSEQ, 1'b0, 32'h0, 2'b10, 1'b1, 32'h4A5A_0004, HRESP_OKAY, 3);
      // 3: unmapped NONSEQ -> ERR1 then ERR2, read data zero
      issue("t3_err", 32'h2000_0000, NONSEQ, 1'b0, 32'h0, 2'b00, 1'b1, 32'h0, HRESP_ERROR, 1);
      drain("t3");
      s1_wait = 0;
`ifdef AHB_IC_ERR_LOG_EN
      check("t6_valid_after_t3", 32'(err_valid), 32'h1);
      check("t6_addr_after_t3",  err_addr,       32'h2000_0000);
`endif

      // 4: back-to-back unmapped NONSEQ -> two full ERROR pairs
      issue("t4_err_a", 32'h2000_0000, NONSEQ, 1'b0, 32'h0, 2'b00, 1'b1, 32'h0, HRESP_ERROR, 1);
      issue("t4_err_b", 32'h3000_0000, NONSEQ, 1'b0, 32'h0, 2'b00, 1'b1, 32'h0, HRESP_ERROR, 1);
      drain("t4");
`ifdef AHB_IC_ERR_LOG_EN
      check("t6_addr_held",  err_addr,       32'h2000_0000);
      check("t6_valid_held", 32'(err_valid), 32'h1);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      check("t6_cleared", 32'(err_valid), 32'h0);
      issue("t6_err_new", 32'h5000_0000, NONSEQ, 1'b0, 32'h0, 2'b00, 1'b1, 32'h0, HRESP_ERROR, 1);
      drain("t6");
      check("t6_recapture_valid", 32'(err_valid), 32'h1);
      check("t6_recapture_addr",  err_addr,       32'h5000_0000);
`endif

      // 5a: IDLE to unmapped space -> OKAY with no wait state
      issue("t5_idle", 32'h2000_0000, IDLE, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, HRESP_OKAY, 0);
      @(negedge clk);
      check("t5_idle_hready", 32'(m_hready), 32'h1);
      check("t5_idle_hresp",  32'(m_hresp),  32'h0);
      @(posedge clk);
      #1;

      // 5b: reset while the default subordinate is in ERR1
      m_haddr  = 32'h2000_0000;
      m_htrans = NONSEQ;
      wait_accept("t5_rst_err");
      m_htrans = IDLE;
      #1;
      check("t5_err1_hready", 32'(m_hready), 32'h0);
      check("t5_err1_hresp",  32'(m_hresp),  32'h1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_hready", 32'(m_hready), 32'h1);
      check("t5_rst_hresp",  32'(m_hresp),  32'h0);
      check("t5_rst_hrdata", m_hrdata,      32'h0);
`ifdef AHB_IC_ERR_LOG_EN
      check("t5_rst_err_valid", 32'(err_valid), 32'h0);
`endif
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // first transfers after release start clean
      issue("t5_post_rd0", 32'h0000_0010, NONSEQ, 1'b0, 32'h0, 2'b01, 1'b1, 32'hDEAD_BEEF, HRESP_OKAY, 0);
      issue("t5_post_rd1", 32'h1000_0008, NONSEQ, 1'b0, 32'h0, 2'b10, 1'b1, 32'h4A5A_0008, HRESP_OKAY, 0);
      drain("t5_post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
